// File: rtl/vin_packer_if.sv
// Stream bundle for vin_packer: video pixel input, packed-word output
// with valid/ready, and the status/error sideband.
interface vin_packer_if #(
  parameter int PIX_W = 8,
  parameter int PACK  = 2
);
  logic                  v_vsync;
  logic                  v_de;
  logic [PIX_W-1:0]      v_pixel;
  logic [PIX_W*PACK-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sof;
  logic                  out_eol;
  logic                  frame_done;
  logic                  err_clr;
  logic                  frame_err;
  logic                  overflow;

  modport master (
    output v_vsync, v_de, v_pixel, out_ready, err_clr,
    input  out_data, out_valid, out_sof, out_eol, frame_done, frame_err, overflow
  );

  modport slave (
    input  v_vsync, v_de, v_pixel, out_ready, err_clr,
    output out_data, out_valid, out_sof, out_eol, frame_done, frame_err, overflow
  );
endinterface

// File: rtl/vin_packer.sv
// Packs PACK video pixels per word into a first-word-fall-through FIFO,
// tagging start-of-frame / end-of-line and flagging length errors and overflow.
module vin_packer #(
  parameter int PIX_W = 8,
  parameter int PACK  = 2,
  parameter int H_ACT = 800,
  parameter int V_ACT = 1200,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  vin_packer_if.slave  bus
);
  localparam int WW = PIX_W * PACK;
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(H_ACT + 1);
  localparam int VW = $clog2(V_ACT + 1);
  localparam int SW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [HW-1:0] H_ACT_L   = HW'(H_ACT);
  localparam logic [VW-1:0] V_ACT_L   = VW'(V_ACT);
  localparam logic [SW-1:0] LAST_SLOT = SW'(PACK - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         vsync_q, de_q;
  logic [SW-1:0]                slot_q, slot_d;
  logic [PACK-1:0][PIX_W-1:0]   part_q, part_d;
  logic [HW-1:0]                pix_cnt_q, pix_cnt_d;
  logic [VW-1:0]                line_cnt_q, line_cnt_d;
  logic                         pend_q, pend_d;
  logic [WW-1:0]                pend_word_q, pend_word_d;
  logic                         sof_arm_q, sof_arm_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                  count_q, count_d;
  logic                         frame_done_q, frame_done_d;
  logic                         frame_err_q, frame_err_d;
  logic                         overflow_q, overflow_d;

  logic [WW+1:0]                fifo_mem [DEPTH];
  logic [WW+1:0]                rd_entry;
  logic                         vs_rise, line_end, push, push_eol, mem_we, pop;
  logic                         err_ev, ovf_ev, flush;
  logic [WW-1:0]                push_word;

  assign vs_rise  = bus.v_vsync & ~vsync_q;
  assign line_end = de_q & ~bus.v_de;
  assign pop      = bus.out_ready && (count_q != '0);

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    part_d       = part_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    pend_d       = 1'b0;
    pend_word_d  = pend_word_q;
    sof_arm_d    = sof_arm_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    push_word    = '0;
    push_eol     = 1'b0;
    err_ev       = 1'b0;
    flush        = 1'b0;

    if (vs_rise) begin
      if (state_q == ACTIVE && line_cnt_q != V_ACT_L) err_ev = 1'b1;
      state_d    = ACTIVE;
      flush      = 1'b1;
      slot_d     = '0;
      part_d     = '0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      sof_arm_d  = 1'b1;
    end else begin
      // A completed word waits one cycle so a line end seen next cycle can tag it eol.
      if (pend_q) begin
        push      = 1'b1;
        push_word = pend_word_q;
        push_eol  = line_end;
      end
      if (state_q == ACTIVE) begin
        if (bus.v_de) begin
          part_d[slot_q] = bus.v_pixel;
          pix_cnt_d      = pix_cnt_q + 1'b1;
          if (slot_q == LAST_SLOT) begin
            pend_d      = 1'b1;
            pend_word_d = part_d;
            part_d      = '0;
            slot_d      = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else if (line_end) begin
          if (slot_q != '0) begin
            push      = 1'b1;
            push_word = part_q;
            push_eol  = 1'b1;
            part_d    = '0;
            slot_d    = '0;
          end
          if (pix_cnt_q != H_ACT_L) err_ev = 1'b1;
          pix_cnt_d  = '0;
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_d == V_ACT_L) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      if (push) sof_arm_d = 1'b0;
    end
  end

  always_comb begin
    mem_we   = push && ((count_q != DEPTH_L) || pop);
    ovf_ev   = push && (count_q == DEPTH_L) && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      case ({mem_we, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    frame_err_d = err_ev | (frame_err_q & ~bus.err_clr);
    overflow_d  = ovf_ev | (overflow_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_SOF;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      slot_q       <= '0;
      part_q       <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      pend_q       <= 1'b0;
      pend_word_q  <= '0;
      sof_arm_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= bus.v_vsync;
      de_q         <= bus.v_de;
      slot_q       <= slot_d;
      part_q       <= part_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pend_q       <= pend_d;
      pend_word_q  <= pend_word_d;
      sof_arm_q    <= sof_arm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) fifo_mem[wr_ptr_q] <= {sof_arm_q, push_eol, push_word};
  end

  // Payload is forced to zero whenever the FIFO is empty, so reset clears it too.
  assign rd_entry       = fifo_mem[rd_ptr_q];
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = bus.out_valid ? rd_entry[WW-1:0] : '0;
  assign bus.out_eol    = bus.out_valid & rd_entry[WW];
  assign bus.out_sof    = bus.out_valid & rd_entry[WW+1];
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;
endmodule
